vector_checker: RTL and testbench

Parametrised, synthesizable stimulus/response checker for combinational or multi-cycle datapath units such as the ALU and Shifter. It holds up to DEPTH test vectors (stimulus, expected result, compare mask), applies them one at a time to a DUT through a request/acknowledge handshake, and compares each masked response. It reports pass/fail counts, the first failing index and a timeout flag. It sits beside the DUT in on-chip self-test and in regression benches, replacing per-unit hand-written checking loops.

---
 rtl/vector_checker.sv | 201 ++++++++++++++++++++
 tb/tb_vector_checker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker.sv
// Stimulus/response checker: applies stored vectors to a DUT over a req/ack
// handshake and compares masked responses, reporting pass/fail statistics.
module vector_checker #(
    parameter int unsigned IN_W    = 68,
    parameter int unsigned OUT_W   = 34,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_stim,
    input  logic [OUT_W-1:0] ld_exp,
    input  logic [OUT_W-1:0] ld_mask,
    input  logic             start,
    input  logic [AW:0]      num_tests,
    input  logic             stop_on_fail,
    output logic [IN_W-1:0]  dut_in,
    output logic             dut_req,
    input  logic             dut_ack,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      pass_cnt,
    output logic [AW:0]      fail_cnt,
    output logic             first_fail_valid,
    output logic [AW-1:0]    first_fail_idx,
    output logic             timeout_err
);

    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, APPLY, WAIT, CHECK} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d, idx_nxt;
    logic [AW:0]      n_q, n_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OUT_W-1:0] cap_q, cap_d;
    logic             to_q, to_d;
    logic             stop_q, stop_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic             dut_req_q, dut_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW:0]      pass_q, pass_d;
    logic [AW:0]      fail_q, fail_d;
    logic             ffv_q, ffv_d;
    logic [AW-1:0]    ffi_q, ffi_d;
    logic             terr_q, terr_d;
    logic             chk_fail;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    // Vector memory has no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == IDLE)) begin
            stim_mem[ld_addr] <= ld_stim;
            exp_mem[ld_addr]  <= ld_exp;
            mask_mem[ld_addr] <= ld_mask;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        timer_d   = timer_q;
        cap_d     = cap_q;
        to_d      = to_q;
        stop_d    = stop_q;
        dut_in_d  = dut_in_q;
        dut_req_d = 1'b0;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
        terr_d    = terr_q;
        idx_nxt   = idx_q + AW'(1);
        chk_fail  = to_q || (((cap_q ^ exp_mem[idx_q]) & mask_mem[idx_q]) != '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    pass_d = '0;
                    fail_d = '0;
                    ffv_d  = 1'b0;
                    ffi_d  = '0;
                    terr_d = 1'b0;
                    idx_d  = '0;
                    stop_d = stop_on_fail;
                    n_d    = (num_tests > DEPTH_N) ? DEPTH_N : num_tests;
                    if (n_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = APPLY;
                        dut_req_d = 1'b1;
                        // Forward a same-cycle write to entry 0 so the run sees it.
                        dut_in_d  = (ld_en && (ld_addr == '0)) ? ld_stim : stim_mem[0];
                    end
                end
            end
            APPLY: begin
                state_d = WAIT;
                timer_d = '0;
                to_d    = 1'b0;
            end
            WAIT: begin
                if (dut_ack) begin
                    cap_d   = dut_out;
                    state_d = CHECK;
                end else if (timer_q == T_LAST) begin
                    to_d    = 1'b1;
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (chk_fail) begin
                    fail_d = fail_q + (AW+1)'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                    if (to_q) terr_d = 1'b1;
                end else begin
                    pass_d = pass_q + (AW+1)'(1);
                end
                if ((chk_fail && stop_q) || ({1'b0, idx_q} == (n_q - (AW+1)'(1)))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d     = idx_nxt;
                    dut_in_d  = stim_mem[idx_nxt];
                    dut_req_d = 1'b1;
                    state_d   = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            timer_q   <= '0;
            cap_q     <= '0;
            to_q      <= 1'b0;
            stop_q    <= 1'b0;
            dut_in_q  <= '0;
            dut_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            timer_q   <= timer_d;
            cap_q     <= cap_d;
            to_q      <= to_d;
            stop_q    <= stop_d;
            dut_in_q  <= dut_in_d;
            dut_req_q <= dut_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
            terr_q    <= terr_d;
        end
    end

    assign dut_in           = dut_in_q;
    assign dut_req          = dut_req_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
    assign timeout_err      = terr_q;

endmodule

// File: tb/tb_vector_checker.sv
// Randomized self-checking bench for vector_checker with an ALU-style DUT
// responder and a vector-level reference model.
module tb_vector_checker;
    localparam int IN_W = 68, OUT_W = 34, DEPTH = 32, TIMEOUT = 16, AW = 5;

    typedef struct packed {
        logic [15:0] cyc;
        logic [5:0]  pass;
        logic [5:0]  fail;
        logic        ffv;
        logic [4:0]  ffi;
        logic        terr;
    } res_t;

    logic clk, rst_n, ld_en, start, stop_on_fail, dut_req, dut_ack, busy, done;
    logic [AW-1:0] ld_addr, first_fail_idx;
    logic [IN_W-1:0] ld_stim, dut_in;
    logic [OUT_W-1:0] ld_exp, ld_mask, dut_out;
    logic [AW:0] num_tests, pass_cnt, fail_cnt;
    logic first_fail_valid, timeout_err;

    logic [IN_W-1:0]  m_stim [DEPTH];
    logic [OUT_W-1:0] m_exp  [DEPTH];
    logic [OUT_W-1:0] m_mask [DEPTH];
    int del_tab [DEPTH];   // ack delay in WAIT cycles, 0 = never
    logic ack_tied, ack_r;
    int req_n, cnt;
    int errors = 0, checks = 0;

    vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
        .ld_exp(ld_exp), .ld_mask(ld_mask), .start(start), .num_tests(num_tests),
        .stop_on_fail(stop_on_fail), .dut_in(dut_in), .dut_req(dut_req), .dut_ack(dut_ack),
        .dut_out(dut_out), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .timeout_err(timeout_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] alu(input logic [67:0] s);
        logic [31:0] a, b;
        a = s[31:0];
        b = s[63:32];
        case (s[65:64])
            2'd0: return 34'(a) + 34'(b);
            2'd1: return 34'(a) - 34'(b);
            2'd2: return {2'b00, a ^ b};
            default: return {2'b00, a << b[4:0]};
        endcase
    endfunction

    assign dut_out = alu(dut_in);
    assign dut_ack = ack_tied | ack_r;

    // DUT responder: ack del_tab[k] WAIT cycles after the k-th request of a run.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !busy) begin
            req_n <= 0; cnt <= 0; ack_r <= 1'b0;
        end else if (dut_req) begin
            cnt <= 1; ack_r <= (del_tab[req_n] == 1); req_n <= req_n + 1;
        end else if (cnt != 0) begin
            cnt <= cnt + 1; ack_r <= (del_tab[req_n-1] == cnt + 1);
        end
    end

    function automatic string fmt(input res_t r);
        return $sformatf("cyc=%0d pass=%0d fail=%0d ffv=%0d ffi=%0d terr=%0d",
                         r.cyc, r.pass, r.fail, r.ffv, r.ffi, r.terr);
    endfunction

    function automatic res_t model(input int n, input logic stop);
        res_t r;
        int nn, k;
        logic to, ok;
        r = '0;
        nn = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < nn; i++) begin
            to = !ack_tied && (del_tab[i] == 0);
            k  = ack_tied ? 1 : (to ? TIMEOUT : del_tab[i]);
            r.cyc += 16'(2 + k);
            ok = !to && (((alu(m_stim[i]) ^ m_exp[i]) & m_mask[i]) == '0);
            if (ok) r.pass++;
            else begin
                r.fail++;
                if (!r.ffv) begin r.ffv = 1'b1; r.ffi = 5'(i); end
                if (to) r.terr = 1'b1;
                if (stop) break;
            end
        end
        return r;
    endfunction

    task automatic load(input int i, input logic [67:0] s, input logic [33:0] e, input logic [33:0] m);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'(i); ld_stim = s; ld_exp = e; ld_mask = m;
        m_stim[i] = s; m_exp[i] = e; m_mask[i] = m;
        @(posedge clk); #1 ld_en = 1'b0;
    endtask

    task automatic load_good(input int i);
        logic [67:0] s;
        s = 68'({$urandom, $urandom, $urandom});
        load(i, s, alu(s), '1);
    endtask

    // Runs n vectors and reports observed results; poke drives start/ld_en mid-run.
    task automatic run(input int n, input logic stop, input logic poke, output res_t r);
        int cyc;
        @(negedge clk);
        start = 1'b1; num_tests = 6'(n); stop_on_fail = stop;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1 cyc++;
            if (poke && cyc == 2) begin
                start = 1'b1; num_tests = 6'd1; ld_en = 1'b1; ld_addr = '0;
                ld_stim = ~m_stim[0]; ld_exp = ~alu(m_stim[0]); ld_mask = '1;
            end else begin
                start = 1'b0; ld_en = 1'b0;
            end
        end
        r = '{16'(cyc), pass_cnt, fail_cnt, first_fail_valid, first_fail_idx, timeout_err};
    endtask

    task automatic test_reset;
        checks++;
        if ({dut_in, dut_req, busy, done, pass_cnt, fail_cnt, first_fail_valid, first_fail_idx, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset: outputs=%h required all zero",
                {dut_in, dut_req, busy, done, pass_cnt, fail_cnt, first_fail_valid, first_fail_idx, timeout_err});
        end
    endtask

    task automatic test_basic;
        res_t r, e;
        ack_tied = 1'b1;
        for (int i = 0; i < 17; i++) load_good(i);
        run(17, 1'b0, 1'b0, r);
        e = '{16'd51, 6'd17, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL basic17: got %s required %s", fmt(r), fmt(e)); end
        checks++;
        if (dut_in !== m_stim[16]) begin errors++; $display("FAIL dut_in_hold: got %h required %h", dut_in, m_stim[16]); end
    endtask

    task automatic test_mask;
        res_t r, e;
        load(4, m_stim[4], m_exp[4] ^ 34'd1, '1);
        run(17, 1'b0, 1'b0, r);
        e = '{16'd51, 6'd16, 6'd1, 1'b1, 5'd4, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL exp_flip: got %s required %s", fmt(r), fmt(e)); end
        load(4, m_stim[4], m_exp[4], ~34'd1);
        run(17, 1'b0, 1'b0, r);
        e = '{16'd51, 6'd17, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL mask_clear: got %s required %s", fmt(r), fmt(e)); end
    endtask

    task automatic test_stop_on_fail;
        res_t r, e;
        load(4, m_stim[4], alu(m_stim[4]), '1);
        load(2, m_stim[2], ~alu(m_stim[2]), '1);
        load(5, m_stim[5], ~alu(m_stim[5]), '1);
        run(17, 1'b1, 1'b0, r);
        e = '{16'd9, 6'd2, 6'd1, 1'b1, 5'd2, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL stop_on_fail: got %s required %s", fmt(r), fmt(e)); end
        load(2, m_stim[2], alu(m_stim[2]), '1);
        load(5, m_stim[5], alu(m_stim[5]), '1);
    endtask

    task automatic test_timeout;
        res_t r, e;
        ack_tied = 1'b0; del_tab[0] = 3; del_tab[1] = 0;
        run(2, 1'b0, 1'b0, r);
        e = '{16'd23, 6'd1, 6'd1, 1'b1, 5'd1, 1'b1};
        checks++;
        if (r !== e) begin errors++; $display("FAIL timeout: got %s required %s", fmt(r), fmt(e)); end
        del_tab[0] = TIMEOUT; del_tab[1] = 1;   // ack in the last WAIT cycle still counts
        run(2, 1'b0, 1'b0, r);
        e = '{16'd21, 6'd2, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL ack_last_cycle: got %s required %s", fmt(r), fmt(e)); end
        ack_tied = 1'b1;
    endtask

    task automatic test_zero_and_overflow;
        res_t r, e;
        run(0, 1'b0, 1'b0, r);
        e = '0;
        checks++;
        if (r !== e) begin errors++; $display("FAIL num_zero: got %s required %s", fmt(r), fmt(e)); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL num_zero_done: got %b required 1", done); end
        for (int i = 17; i < DEPTH; i++) load_good(i);
        run(DEPTH + 5, 1'b0, 1'b0, r);
        e = '{16'd96, 6'd32, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL num_overflow: got %s required %s", fmt(r), fmt(e)); end
    endtask

    task automatic test_busy_ignore;
        res_t r, e;
        run(4, 1'b0, 1'b1, r);
        e = '{16'd12, 6'd4, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL busy_start: got %s required %s", fmt(r), fmt(e)); end
        run(1, 1'b0, 1'b0, r);
        e = '{16'd3, 6'd1, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r !== e) begin errors++; $display("FAIL busy_load: got %s required %s", fmt(r), fmt(e)); end
    endtask

    task automatic test_same_cycle;
        logic [67:0] s;
        int cyc;
        load(0, m_stim[0], ~alu(m_stim[0]), '1);
        s = 68'({$urandom, $urandom, $urandom});
        @(negedge clk);
        ld_en = 1'b1; ld_addr = '0; ld_stim = s; ld_exp = alu(s); ld_mask = '1;
        m_stim[0] = s; m_exp[0] = alu(s); m_mask[0] = '1;
        start = 1'b1; num_tests = 6'd1; stop_on_fail = 1'b0;
        @(posedge clk); #1 start = 1'b0; ld_en = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1 cyc++; end
        checks++;
        if ({pass_cnt, fail_cnt} !== {6'd1, 6'd0} || dut_in !== s) begin
            errors++;
            $display("FAIL same_cycle_load: got pass=%0d fail=%0d dut_in=%h required 1 0 %h", pass_cnt, fail_cnt, dut_in, s);
        end
    endtask

    task automatic test_reset_midrun;
        res_t r1, r2, e;
        ack_tied = 1'b0;
        for (int i = 0; i < DEPTH; i++) del_tab[i] = 2;
        run(6, 1'b0, 1'b0, r1);
        e = '{16'd24, 6'd6, 6'd0, 1'b0, 5'd0, 1'b0};
        checks++;
        if (r1 !== e) begin errors++; $display("FAIL pre_reset_run: got %s required %s", fmt(r1), fmt(e)); end
        @(negedge clk);
        start = 1'b1; num_tests = 6'd6;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b required 1", busy); end
        rst_n = 1'b0;
        #1 test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(6, 1'b0, 1'b0, r2);
        checks++;
        if (r2 !== r1) begin errors++; $display("FAIL rerun_after_reset: got %s required %s", fmt(r2), fmt(r1)); end
        ack_tied = 1'b1;
    endtask

    task automatic test_random;
        res_t r, e;
        logic [67:0] s;
        logic [33:0] ex, mk;
        int n;
        logic stop;
        for (int it = 0; it < 8; it++) begin
            ack_tied = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < DEPTH; i++) begin
                s  = 68'({$urandom, $urandom, $urandom});
                ex = alu(s);
                mk = ($urandom_range(0, 1) == 0) ? '1 : 34'({$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) ex[$urandom_range(0, 33)] ^= 1'b1;
                load(i, s, ex, mk);
                del_tab[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            end
            n = int'($urandom_range(0, DEPTH + 6));
            stop = 1'($urandom_range(0, 1));
            run(n, stop, 1'b0, r);
            e = model(n, stop);
            checks++;
            if (r !== e) begin errors++; $display("FAIL random%0d n=%0d stop=%0d: got %s required %s", it, n, stop, fmt(r), fmt(e)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_stim = '0; ld_exp = '0; ld_mask = '0;
        start = 1'b0; num_tests = '0; stop_on_fail = 1'b0; ack_tied = 1'b1;
        for (int i = 0; i < DEPTH; i++) del_tab[i] = 1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_reset();
        test_basic();
        test_mask();
        test_stop_on_fail();
        test_timeout();
        test_zero_and_overflow();
        test_busy_ignore();
        test_same_cycle();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
